// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues in-order read requests to instruction
// memory, tracks outstanding responses, and buffers returned words in a
// two-entry queue that feeds decode.
//
// Parameters
//   RESET_VECTOR       first instruction address fetched after reset
//
// Ports
//   CLOCK_50           clock, all state updates on the rising edge
//   RESET              asynchronous active-high reset
//   ins_mem_addr       request address (current PC)
//   ins_mem_req        read request
//   ins_mem_gnt        request accepted when req and gnt are both high
//   ins_mem_rvalid     response valid, responses arrive in request order
//   ins_mem_ins        response instruction word
//   redirect_valid     one-cycle PC redirect (branch/jump/trap)
//   redirect_addr      redirect target
//   fetch_valid        queue head is valid
//   fetch_ins          queue-head instruction
//   fetch_pc           queue-head instruction address
//   decode_ready       pops the queue head when fetch_valid is high
//   fetch_misaligned   sticky misaligned-redirect flag
//
// Configuration
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a non word-aligned
//                           target parks the unit in a halt state with
//                           fetch_misaligned set until an aligned redirect.
//                           When undefined, the target's low two bits are
//                           cleared and fetch_misaligned is tied low.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  output logic [31:0] ins_mem_addr,
  output logic        ins_mem_req,
  input  logic        ins_mem_gnt,
  input  logic        ins_mem_rvalid,
  input  logic [31:0] ins_mem_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_ins,
  output logic [31:0] fetch_pc,
  input  logic        decode_ready,
  output logic        fetch_misaligned
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;
`else
  typedef enum logic [1:0] {StBoot, StRun} state_e;
`endif

  // Control state
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  out_q, out_d;    // requests granted but not yet answered
  logic [1:0]  disc_q, disc_d;  // responses still to be thrown away
  logic [1:0]  cnt_q, cnt_d;    // instruction queue occupancy
  logic        head_q, head_d;

  // Instruction queue storage
  logic [31:0] q_ins_q [2];
  logic [31:0] q_pc_q  [2];

  // Address of each granted request, consumed in order as responses return
  logic [31:0] rsp_pc_q [2];
  logic        rsp_wr_q, rsp_rd_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  logic        grant;
  logic        rsp;
  logic        push;
  logic        pop;
  logic        wr_idx;
  logic [2:0]  occupancy;
  logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt = redirect_addr;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_addr[1:0];
  assign redir_tgt = {redirect_addr[31:2], 2'b00};
`endif

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign fetch_valid = (cnt_q != 2'd0) && !redirect_valid;
  assign fetch_ins   = (cnt_q != 2'd0) ? q_ins_q[head_q] : 32'h0;
  assign fetch_pc    = (cnt_q != 2'd0) ? q_pc_q[head_q]  : 32'h0;

  assign pop   = fetch_valid && decode_ready;
  assign grant = ins_mem_req && ins_mem_gnt;

  // A response with nothing outstanding is a leftover from before a reset.
  assign rsp  = ins_mem_rvalid && (out_q != 2'd0);
  assign push = rsp && !redirect_valid && (disc_q == 2'd0);

  // Slot written by a push: head + count, modulo 2. On a full queue this is
  // the head slot, which is only legal because the same cycle pops it.
  assign wr_idx = head_q ^ cnt_q[0];

  // Every granted request owns a queue slot until it is consumed. A slot
  // freed by this cycle's pop may be claimed again straight away, which is
  // what sustains one instruction per cycle with a one-cycle memory.
  assign occupancy = {1'b0, cnt_q} + {1'b0, out_q} - {2'b00, pop};

  assign ins_mem_addr = pc_q;
  assign ins_mem_req  = (state_q == StRun) && !redirect_valid && (occupancy < 3'd2);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = mis_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
`ifdef FETCH_MISALIGN_TRAP_EN
      StHalt:  state_d = StHalt;
`endif
      default: state_d = StBoot;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // Any redirect re-decides between trapping and running.
    if (redirect_valid) begin
      mis_d   = |redirect_addr[1:0];
      state_d = mis_d ? StHalt : StRun;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + {1'b0, grant} - {1'b0, rsp};
    disc_d = disc_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path; drop it all.
      pc_d   = redir_tgt;
      disc_d = out_d;
      cnt_d  = 2'd0;
      head_d = 1'b0;
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp && (disc_q != 2'd0)) begin
        disc_d = disc_q - 2'd1;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head_d = ~head_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= StBoot;
      pc_q     <= RESET_VECTOR;
      out_q    <= 2'd0;
      disc_q   <= 2'd0;
      cnt_q    <= 2'd0;
      head_q   <= 1'b0;
      rsp_wr_q <= 1'b0;
      rsp_rd_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_ins_q[i]  <= 32'h0;
        q_pc_q[i]   <= 32'h0;
        rsp_pc_q[i] <= 32'h0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
      if (grant) begin
        rsp_pc_q[rsp_wr_q] <= pc_q;
        rsp_wr_q           <= ~rsp_wr_q;
      end
      if (rsp) begin
        rsp_rd_q <= ~rsp_rd_q;
      end
      if (push) begin
        q_ins_q[wr_idx] <= ins_mem_ins;
        q_pc_q[wr_idx]  <= rsp_pc_q[rsp_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (default build, FETCH_MISALIGN_TRAP_EN undefined).
// The model only knows program order: each grant must ask for the next
// sequential address and each decode pop must deliver the next sequential
// {pc, mem[pc]}, both restarting at the reset vector or the redirect target.
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [31:0] ins_mem_addr;
  logic        ins_mem_req;
  logic        ins_mem_gnt;
  logic        ins_mem_rvalid;
  logic [31:0] ins_mem_ins;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        fetch_valid;
  logic [31:0] fetch_ins;
  logic [31:0] fetch_pc;
  logic        decode_ready;
  logic        fetch_misaligned;

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .CLOCK_50        (CLOCK_50),
    .RESET           (RESET),
    .ins_mem_addr    (ins_mem_addr),
    .ins_mem_req     (ins_mem_req),
    .ins_mem_gnt     (ins_mem_gnt),
    .ins_mem_rvalid  (ins_mem_rvalid),
    .ins_mem_ins     (ins_mem_ins),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .fetch_valid     (fetch_valid),
    .fetch_ins       (fetch_ins),
    .fetch_pc        (fetch_pc),
    .decode_ready    (decode_ready),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;

  // Stimulus intent, applied at the next step
  logic        gnt, ready, rst_req, redir_req;
  logic [31:0] redir_tgt;

  // Model state
  logic [31:0] exp_req, exp_pc;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];
  int          mark;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    pop_log.delete();
    pop_cyc.delete();
  endtask

  task automatic compare();
    check("misaligned_low", {31'b0, fetch_misaligned}, 32'd0);
    if (RESET) begin
      check("reset_req", {31'b0, ins_mem_req}, 32'd0);
      check("reset_valid", {31'b0, fetch_valid}, 32'd0);
      exp_req = RV;
      exp_pc  = RV;
      return;
    end
    if (redirect_valid) begin
      check("redirect_req", {31'b0, ins_mem_req}, 32'd0);
      check("redirect_valid", {31'b0, fetch_valid}, 32'd0);
      exp_req = redirect_addr & 32'hFFFF_FFFC;
      exp_pc  = redirect_addr & 32'hFFFF_FFFC;
      return;
    end
    if (ins_mem_req && ins_mem_gnt) begin
      check("grant_addr", ins_mem_addr, exp_req);
      grant_log.push_back(ins_mem_addr);
      grant_cyc.push_back(cyc);
      mq_addr.push_back(ins_mem_addr);
      mq_due.push_back(cyc + lat);
      exp_req = exp_req + 32'd4;
    end
    if (fetch_valid && decode_ready) begin
      check("fetch_pc", fetch_pc, exp_pc);
      check("fetch_ins", fetch_ins, mem_word(exp_pc));
      pop_log.push_back(fetch_pc);
      pop_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic step();
    @(negedge CLOCK_50);
    cyc++;
    ins_mem_rvalid = 1'b0;
    ins_mem_ins    = 32'h0;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      ins_mem_rvalid = 1'b1;
      ins_mem_ins    = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    redirect_valid = redir_req;
    redirect_addr  = redir_tgt;
    redir_req      = 1'b0;
    RESET          = rst_req;
    ins_mem_gnt    = gnt;
    decode_ready   = ready;
    #1;
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; rst_req = 1'b1;
    gnt = 1'b0; ready = 1'b0; redir_req = 1'b0; redir_tgt = 32'h0;
    ins_mem_gnt = 1'b0; ins_mem_rvalid = 1'b0; ins_mem_ins = 32'h0;
    redirect_valid = 1'b0; redirect_addr = 32'h0; decode_ready = 1'b0;
    exp_req = RV; exp_pc = RV;
    #2;
    check("rst_ins_mem_req", {31'b0, ins_mem_req}, 32'd0);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_fetch_ins", fetch_ins, 32'h0);
    check("rst_ins_mem_addr", ins_mem_addr, RV);
    step(); step();

    // Streaming from reset: boot cycle, then one instruction per cycle
    rst_req = 1'b0; gnt = 1'b1; ready = 1'b1;
    clear_logs();
    step();
    mark = cyc;
    check("boot_no_req", {31'b0, ins_mem_req}, 32'd0);
    repeat (7) step();
    check("stream_grants", grant_log.size(), 32'd7);
    check("stream_pops", pop_log.size(), 32'd5);
    if (grant_log.size() >= 3 && pop_log.size() >= 3) begin
      check("first_grant_cyc", grant_cyc[0], mark + 1);
      check("grant0", grant_log[0], 32'h0);
      check("grant1", grant_log[1], 32'h4);
      check("grant2", grant_log[2], 32'h8);
      check("pop0", pop_log[0], 32'h0);
      check("pop1", pop_log[1], 32'h4);
      check("pop2", pop_log[2], 32'h8);
      check("pop_back_to_back", pop_cyc[2] - pop_cyc[0], 32'd2);
    end

    // Decode stall: queue fills to two, requests stop
    ready = 1'b0;
    clear_logs();
    repeat (5) step();
    check("stall_grants", grant_log.size(), 32'd0);
    check("stall_req_low", {31'b0, ins_mem_req}, 32'd0);
    check("stall_valid", {31'b0, fetch_valid}, 32'd1);
    check("stall_head_pc", fetch_pc, 32'h14);
    gnt = 1'b0; ready = 1'b1;
    clear_logs();
    repeat (3) step();
    check("drain_pops", pop_log.size(), 32'd2);
    if (pop_log.size() == 2) begin
      check("drain_pop0", pop_log[0], 32'h14);
      check("drain_pop1", pop_log[1], 32'h18);
    end
    check("drain_empty", {31'b0, fetch_valid}, 32'd0);

    // Redirect with two requests outstanding
    gnt = 1'b1; lat = 3;
    clear_logs();
    step(); step();
    check("pre_redir_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      check("pre_redir_g0", grant_log[0], 32'h1C);
      check("pre_redir_g1", grant_log[1], 32'h20);
    end
    redir_req = 1'b1; redir_tgt = 32'h100; lat = 1;
    clear_logs();
    step();
    mark = cyc;
    repeat (7) step();
    check("redir_grant_seen", {31'b0, grant_log.size() != 0}, 32'd1);
    check("redir_pop_seen", {31'b0, pop_log.size() != 0}, 32'd1);
    if (grant_log.size() != 0 && pop_log.size() != 0) begin
      check("redir_first_grant", grant_log[0], 32'h100);
      check("redir_grant_wait", grant_cyc[0], mark + 2);
      check("redir_first_pop", pop_log[0], 32'h100);
    end

    // PC wrap at the top of the address space
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    clear_logs();
    repeat (8) step();
    check("wrap_pops", pop_log.size(), 32'd5);
    if (grant_log.size() >= 3 && pop_log.size() >= 3) begin
      check("wrap_g0", grant_log[0], 32'hFFFF_FFF8);
      check("wrap_g1", grant_log[1], 32'hFFFF_FFFC);
      check("wrap_g2", grant_log[2], 32'h0000_0000);
      check("wrap_p2", pop_log[2], 32'h0000_0000);
    end

    // Reset with one request in flight; its late response must be ignored
    gnt = 1'b0;
    repeat (4) step();
    lat = 4; gnt = 1'b1;
    clear_logs();
    step();
    check("inflight_grant", grant_log.size(), 32'd1);
    gnt = 1'b0; rst_req = 1'b1;
    step(); step();
    rst_req = 1'b0; gnt = 1'b1; lat = 1;
    clear_logs();
    repeat (6) step();
    check("post_reset_pop_seen", {31'b0, pop_log.size() != 0}, 32'd1);
    if (pop_log.size() != 0) begin
      check("post_reset_first_pc", pop_log[0], RV);
    end

    // Misaligned redirect target is word-aligned in this build
    redir_req = 1'b1; redir_tgt = 32'h102;
    clear_logs();
    repeat (6) step();
    check("mis_misaligned_flag", {31'b0, fetch_misaligned}, 32'd0);
    if (grant_log.size() != 0 && pop_log.size() != 0) begin
      check("mis_first_grant", grant_log[0], 32'h100);
      check("mis_first_pop", pop_log[0], 32'h100);
    end else begin
      check("mis_activity", 32'd0, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
